// File: rtl/video_pattern_generator_ycbcr.sv
// video_pattern_generator_ycbcr: raster-timed YCbCr 4:2:2 test-pattern source
// with colour bars, luma ramp, checkerboard and a moving bar.
module video_pattern_generator_ycbcr #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_TOTAL  = 2000,
    parameter int V_TOTAL  = 500,
    parameter int H_START  = 128,
    parameter int V_START  = 16,
    parameter int DATA_W   = 8
) (
    input  logic                clk_25_mhz,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic                video_valid,
    output logic [2*DATA_W-1:0] video_data,
    output logic                video_sof,
    output logic                video_eof,
    output logic [7:0]          frame_cnt
);
    localparam int SH = DATA_W - 8;
    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] HS       = 16'(H_START);
    localparam logic [15:0] HE       = 16'(H_START + H_ACTIVE);
    localparam logic [15:0] VS       = 16'(V_START);
    localparam logic [15:0] VE       = 16'(V_START + V_ACTIVE);
    localparam logic [15:0] X_LAST   = 16'(H_ACTIVE - 1);
    localparam logic [15:0] Y_LAST   = 16'(V_ACTIVE - 1);
    localparam logic [15:0] BAR_LAST = 16'(H_ACTIVE / 8 - 1);
    localparam logic [15:0] HA       = 16'(H_ACTIVE);
    // {Y, Cb, Cr}: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_LUT [8] = '{
        24'hEB8080, 24'hD21092, 24'hAAA610, 24'h913622,
        24'h6ACADE, 24'h515AF0, 24'h29F06E, 24'h108080
    };

    typedef enum logic {IDLE, RUN} state_t;
    typedef logic [DATA_W-1:0] comp_t;

    state_t      state, state_n;
    logic [15:0] h, v, h_n, v_n, x, y, bar_pos, bar_p;
    logic [2:0]  bar_idx;
    logic [1:0]  mode_q;
    logic        act_rows, act, run;
    logic [23:0] bar;
    logic [7:0]  luma, cb, cr;

    always_ff @(posedge clk_25_mhz) state <= reset ? IDLE : state_n;

    always_comb begin
        act_rows = v >= VS && v < VE;
        state_n  = state == IDLE ? (enable ? RUN : IDLE) : (!enable && !act_rows ? IDLE : RUN);
        run      = state == RUN && state_n == RUN;
        h_n      = !run || h == H_LAST ? '0 : h + 16'd1;
        v_n      = !run ? '0 : h != H_LAST ? v : v == V_LAST ? '0 : v + 16'd1;
        x        = h - HS;
        y        = v - VS;
        act      = state == RUN && act_rows && h >= HS && h < HE;
        bar      = BAR_LUT[bar_idx];
        luma     = mode_q == 2'd0 ? bar[23:16] :
                   mode_q == 2'd1 ? x[7:0] :
                   mode_q == 2'd2 ? (x[5] ^ y[5] ? 8'd235 : 8'd16) :
                   (x >= bar_p && x < bar_p + 16'd16 ? 8'd235 : 8'd16);
        cb       = mode_q == 2'd0 ? bar[15:8] : 8'd128;
        cr       = mode_q == 2'd0 ? bar[7:0] : 8'd128;
    end

    always_ff @(posedge clk_25_mhz) begin
        if (reset) begin
            h           <= '0;
            v           <= '0;
            mode_q      <= '0;
            bar_p       <= '0;
            bar_pos     <= '0;
            bar_idx     <= '0;
            frame_cnt   <= '0;
            video_valid <= 1'b0;
            video_data  <= '0;
            video_sof   <= 1'b0;
            video_eof   <= 1'b0;
        end else begin
            h <= h_n;
            v <= v_n;
            if (h == '0 && v == '0) begin
                mode_q <= mode;
                bar_p  <= {5'd0, frame_cnt, 3'd0} % HA;
            end
            // bar position tracks the pixel that h_n will present, restarting at x=0
            bar_pos <= h_n == HS || bar_pos == BAR_LAST ? '0 : bar_pos + 16'd1;
            if (h_n == HS)
                bar_idx <= '0;
            else if (bar_pos == BAR_LAST)
                bar_idx <= bar_idx + 3'd1;
            video_valid <= act;
            video_data  <= act ? {comp_t'(luma) << SH, comp_t'(x[0] ? cr : cb) << SH} : '0;
            video_sof   <= act && x == '0 && y == '0;
            video_eof   <= act && x == X_LAST && y == Y_LAST;
            if (video_eof)
                frame_cnt <= frame_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_video_pattern_generator_ycbcr.sv
// tb_video_pattern_generator_ycbcr: scoreboard bench for the YCbCr pattern generator
// using a small raster so many frames fit in a short run.
module tb_video_pattern_generator_ycbcr;
    localparam int HA = 64, VA = 34, HT = 100, VT = 40, HS = 10, VS = 2, DW = 10;
    localparam int FR = HT * VT;
    localparam int TY  [8] = '{235, 210, 170, 145, 106, 81, 41, 16};
    localparam int TCB [8] = '{128, 16, 166, 54, 202, 90, 240, 128};
    localparam int TCR [8] = '{128, 146, 16, 34, 222, 240, 110, 128};

    typedef struct {
        longint            cyc;
        logic [2*DW-1:0]   d;
        logic              sof;
        logic              eof;
    } beat_t;

    logic            clk = 1'b0, reset = 1'b1, enable = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic            video_valid, video_sof, video_eof;
    logic [2*DW-1:0] video_data;
    logic [7:0]      frame_cnt;

    int     checks = 0, fails = 0;
    int     n_beats = 0, n_sof = 0, n_eof = 0, exp_fc = 0;
    bit     fc_chk = 0;
    longint cyc = 0, k0 = 0;
    beat_t  sb[$];
    beat_t  mb;

    video_pattern_generator_ycbcr #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT),
        .H_START(HS), .V_START(VS), .DATA_W(DW)
    ) dut (
        .clk_25_mhz(clk), .reset(reset), .enable(enable), .mode(mode),
        .video_valid(video_valid), .video_data(video_data),
        .video_sof(video_sof), .video_eof(video_eof), .frame_cnt(frame_cnt)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*DW-1:0] model_pix(input int m, input int x, input int y, input int fc);
        int yy, cb, cr, p, b;
        cb = 128;
        cr = 128;
        b  = x / (HA / 8);
        p  = (fc * 8) % HA;
        if (m == 0) begin
            yy = TY[b];
            cb = TCB[b];
            cr = TCR[b];
        end else if (m == 1) yy = x % 256;
        else if (m == 2) yy = (((x / 32) % 2) != ((y / 32) % 2)) ? 235 : 16;
        else yy = (x >= p && x < p + 16) ? 235 : 16;
        return {DW'(yy << (DW - 8)), DW'(((x % 2) == 0 ? cb : cr) << (DW - 8))};
    endfunction

    task automatic push_frame(input longint base, input int m, input int fc);
        beat_t b;
        for (int yi = 0; yi < VA; yi++)
            for (int xi = 0; xi < HA; xi++) begin
                b.cyc = base + longint'((VS + yi) * HT + HS + xi + 1);
                b.d   = model_pix(m, xi, yi, fc);
                b.sof = xi == 0 && yi == 0;
                b.eof = xi == HA - 1 && yi == VA - 1;
                sb.push_back(b);
            end
    endtask

    task automatic wait_sig(input bit want_eof, input int lim, output bit ok);
        ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (want_eof ? video_eof : video_sof) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Scoreboard monitor: every valid beat must match the next expected beat, cycle included.
    always @(negedge clk) begin
        if (reset) begin
            exp_fc = 0;
            fc_chk = 0;
        end else if (fc_chk) begin
            fc_chk = 0;
            checks++;
            if (frame_cnt !== 8'(exp_fc)) begin
                fails++;
                $display("FAIL frame_cnt: got %0d expected %0d", frame_cnt, exp_fc);
            end
        end
        if (video_valid) begin
            n_beats++;
            n_sof += int'(video_sof);
            n_eof += int'(video_eof);
            checks++;
            if (sb.size() == 0) begin
                fails++;
                if (fails <= 30) $display("FAIL unexpected_beat: cycle %0d data %h", cyc, video_data);
            end else begin
                mb = sb.pop_front();
                if (video_data !== mb.d || video_sof !== mb.sof || video_eof !== mb.eof || cyc != mb.cyc) begin
                    fails++;
                    if (fails <= 30)
                        $display("FAIL beat: got cyc %0d data %h sof %b eof %b, expected cyc %0d data %h sof %b eof %b",
                                 cyc, video_data, video_sof, video_eof, mb.cyc, mb.d, mb.sof, mb.eof);
                end
                if (mb.eof) begin
                    exp_fc++;
                    fc_chk = 1;
                end
            end
        end else if (!reset) begin
            checks++;
            if (video_data !== '0 || video_sof !== 1'b0 || video_eof !== 1'b0) begin
                fails++;
                if (fails <= 30) $display("FAIL blank_outputs: data %h sof %b eof %b", video_data, video_sof, video_eof);
            end
        end
    end

    task automatic run_frame(input int f, input int m, input int nxt);
        bit ok;
        push_frame(k0 + longint'(f) * FR, m, f);
        wait_sig(0, 2 * FR, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL sof_timeout: frame %0d got none required 1", f); end
        mode = 2'(m ^ 1);
        wait_sig(1, FR, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL eof_timeout: frame %0d got none required 1", f); end
        mode = 2'(nxt);
    endtask

    task automatic test_reset;
        reset  = 1;
        enable = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (video_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", video_valid); end
        checks++;
        if (video_data !== '0) begin fails++; $display("FAIL reset_data: got %h required 0", video_data); end
        checks++;
        if (video_sof !== 1'b0 || video_eof !== 1'b0) begin fails++; $display("FAIL reset_sof_eof: got %b%b required 00", video_sof, video_eof); end
        checks++;
        if (frame_cnt !== 8'd0) begin fails++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
        reset = 0;
        repeat (50) @(negedge clk);
        checks++;
        if (n_beats != 0) begin fails++; $display("FAIL idle_beats: got %0d required 0", n_beats); end
    endtask

    task automatic test_color_bars;
        bit ok;
        mode    = 2'd0;
        n_beats = 0;
        n_sof   = 0;
        n_eof   = 0;
        enable  = 1;
        k0      = cyc + 1;
        push_frame(k0, 0, 0);
        wait_sig(0, 2 * FR, ok);
        checks++;
        if (!ok || cyc != k0 + VS * HT + HS + 1) begin fails++; $display("FAIL first_beat_time: got %0d required %0d", cyc, k0 + VS * HT + HS + 1); end
        checks++;
        if (video_data !== {10'd940, 10'd512}) begin fails++; $display("FAIL first_beat_data: got %h required %h", video_data, {10'd940, 10'd512}); end
        mode = 2'd3;
        wait_sig(1, FR, ok);
        checks++;
        if (!ok || video_data !== {10'd64, 10'd512}) begin fails++; $display("FAIL eof_data: got %h required %h", video_data, {10'd64, 10'd512}); end
        mode = 2'd1;
        @(negedge clk);
        checks++;
        if (n_beats != HA * VA) begin fails++; $display("FAIL frame_beats: got %0d required %0d", n_beats, HA * VA); end
        checks++;
        if (n_sof != 1 || n_eof != 1) begin fails++; $display("FAIL sof_eof_count: got %0d/%0d required 1/1", n_sof, n_eof); end
    endtask

    task automatic test_modes;
        run_frame(1, 1, 2);
        run_frame(2, 2, 3);
    endtask

    task automatic test_moving_bar;
        for (int f = 3; f <= 8; f++) run_frame(f, 3, 3);
    endtask

    task automatic test_enable_drop;
        bit ok;
        longint k2;
        push_frame(k0 + 9 * FR, 3, 9);
        wait_sig(0, 2 * FR, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL drop_sof_timeout: got none required 1"); end
        repeat (10 * HT) @(negedge clk);
        enable = 0;
        wait_sig(1, FR, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL drop_eof_timeout: got none required 1"); end
        @(negedge clk);
        n_beats = 0;
        repeat (FR + HT) @(negedge clk);
        checks++;
        if (n_beats != 0) begin fails++; $display("FAIL beats_after_drop: got %0d required 0", n_beats); end
        enable = 1;
        k2     = cyc + 1;
        push_frame(k2, 3, 10);
        wait_sig(0, 2 * FR, ok);
        checks++;
        if (!ok || cyc != k2 + VS * HT + HS + 1) begin fails++; $display("FAIL restart_sof_time: got %0d required %0d", cyc, k2 + VS * HT + HS + 1); end
    endtask

    task automatic test_reset_mid;
        repeat (20 * HT) @(negedge clk);
        reset  = 1;
        enable = 0;
        @(negedge clk);
        checks++;
        if (video_valid !== 1'b0 || video_data !== '0) begin fails++; $display("FAIL mid_reset_outputs: got %b %h required 0 0", video_valid, video_data); end
        checks++;
        if (frame_cnt !== 8'd0) begin fails++; $display("FAIL mid_reset_frame_cnt: got %0d required 0", frame_cnt); end
        sb.delete();
        @(negedge clk);
        reset   = 0;
        n_beats = 0;
        repeat (FR) @(negedge clk);
        checks++;
        if (n_beats != 0) begin fails++; $display("FAIL beats_after_reset: got %0d required 0", n_beats); end
    endtask

    task automatic test_back_to_back;
        mode   = 2'd2;
        enable = 1;
        k0     = cyc + 1;
        run_frame(0, 2, 2);
        run_frame(1, 2, 2);
        enable = 0;
        repeat (HT) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin fails++; $display("FAIL missing_beats: got %0d left required 0", sb.size()); end
    endtask

    initial begin
        test_reset;
        test_color_bars;
        test_modes;
        test_moving_bar;
        test_enable_drop;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/video_pattern_generator_ycbcr.md
# video_pattern_generator_ycbcr

Parametrised successor of the fixed 640x480 colour-bar source: a raster-timed YCbCr 4:2:2 test-pattern generator with configurable active size, blanking, component width and four selectable patterns, one of them animated. It generates pixels arithmetically, with no FIFO or external pattern core. It feeds the video-correction pipeline with the same valid/sof/eof beat stream, so downstream blocks can be exercised at any resolution.

## Interface
- H_ACTIVE, 640, active pixels per line; must be divisible by 8.
- V_ACTIVE, 480, active lines per frame.
- H_TOTAL, 2000, clocks per line including blanking.
- V_TOTAL, 500, lines per frame including blanking.
- H_START, 128, first active column; H_START+H_ACTIVE <= H_TOTAL.
- V_START, 16, first active row; V_START+V_ACTIVE <= V_TOTAL.
- DATA_W, 8, component width; must be >= 8.

- clk_25_mhz  in  1  pixel clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; overrides everything.
- enable  in  1  run request.
- mode  in  2  pattern select: 0 colour bars, 1 luma ramp, 2 checkerboard, 3 moving bar.
- video_valid  out  1  pixel beat valid.
- video_data  out  2*DATA_W  upper half = Y; lower half = Cb on even active columns, Cr on odd active columns.
- video_sof  out  1  asserted with the first pixel of a frame.
- video_eof  out  1  asserted with the last pixel of a frame.
- frame_cnt  out  8  completed-frame counter.

## Operation
- Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1). h wraps and increments v; v wraps at the end of the frame.
- Active region: V_START <= v < V_START+V_ACTIVE and H_START <= h < H_START+H_ACTIVE.
- Active coordinates: x = h-H_START, y = v-V_START.
- FSM IDLE/RUN:
  - IDLE: h=v=0 held. Go to RUN when enable=1.
  - RUN: counters advance every clock.
  - RUN->IDLE when enable=0 and v is outside the active rows. A frame already in its active rows always completes.
- Mode is latched into mode_q at h=0, v=0 of each frame. A mid-frame change of mode has no effect until the next frame.
- Pattern values are 8-bit BT.601, left-shifted by DATA_W-8.
- Mode 0, colour bars:
  - 8 bars, each BAR_W = H_ACTIVE/8 wide. The bar index comes from a sub-counter reset at x=0, not from a divider.
  - Bar order (Y,Cb,Cr): white 235,128,128; yellow 210,16,146; cyan 170,166,16; green 145,54,34; magenta 106,202,222; red 81,90,240; blue 41,240,110; black 16,128,128.
- Mode 1, luma ramp: Y = x[7:0] (wraps every 256 px); Cb = Cr = 128.
- Mode 2, checkerboard: 32x32 squares. Y = 235 if x[5]^y[5], else 16; C = 128.
- Mode 3, moving bar:
  - Black background, 16-px white bar starting at column p.
  - p = (frame_cnt*8) mod H_ACTIVE, computed once per frame at frame start.
  - The bar clips at the right edge; it does not wrap.
- frame_cnt increments on the cycle after each eof beat and wraps 255->0. It is cleared only by reset, not by IDLE.
- Outside the active region video_data = 0 and video_valid = 0.

## Timing
- Reset values: FSM IDLE, h=v=0, mode_q=0, frame_cnt=0, video_valid/sof/eof=0, video_data=0.
- All outputs are registered with 1-cycle latency from the counter state.
- Frame period is H_TOTAL*V_TOTAL clocks (defaults: 1,000,000 clocks = 40 ms = 25 Hz).
- enable sampled high in IDLE at edge k: counter state (0,0) holds after edge k. The first pixel beat (with sof) is present after edge k+V_START*H_TOTAL+H_START+1. Defaults: k+32129.
- sof is a single beat at x=0,y=0. eof is a single beat at x=H_ACTIVE-1, y=V_ACTIVE-1. Both are valid beats that carry pixel data.
- Each active line gives exactly H_ACTIVE consecutive valid beats; no gaps inside a line.
- Reset mid-frame: the next cycle's outputs are 0 and the in-flight frame is abandoned with no eof.
- enable toggling inside the active rows has no effect until the frame's active rows end.
- enable held high: frames run back-to-back, and sof recurs exactly every H_TOTAL*V_TOTAL clocks.

## Test plan
- Defaults, mode 0, enable rises at edge k: first beat after edge k+32129 with sof=1 and data {235,128}. Beat x=1 is {235,128}; beat x=80 is {210,16}.
- Defaults, full frame: 307,200 valid beats. Exactly one sof and one eof, eof data {16,128}. frame_cnt reads 1 one cycle after eof.
- Mode 1: beat at x=300 is {44,128}. Mode 2: beat at x=32,y=0 is {235,128}; at x=32,y=32 is {16,128}.
- Mode 3 over frames 0..2: white bar starts at x=0, 8, 16 respectively. With H_ACTIVE=64 and frame_cnt=7, p=56 and the bar clips at x=63.
- Drop enable at y=100: the frame completes with eof, the FSM enters IDLE, and no beats follow. Raise enable again: the new sof arrives after 32129 edges.
- Assert reset at y=200: outputs go to 0 the next cycle, and frame_cnt=0. Also non-default parameters H_ACTIVE=64, V_ACTIVE=4, H_TOTAL=100, V_TOTAL=8, H_START=10, V_START=2, DATA_W=10: 256 beats per frame, white Y = 940.
